// File: rtl/sensor_scheduler_rr.sv
// sensor_scheduler_rr
// Arbitrates buffered one-shot UART read commands and round-robin continuous
// temperature/humidity monitoring over N_SENSORS sensor interface channels.
// Every sensor access is bounded by a timeout. The selected result is handed to
// the response decoder and held there until the decoder reports completion.
module sensor_scheduler_rr #(
  parameter int         N_SENSORS    = 8,
  parameter int         TIMEOUT_CYC  = 50000000,
  parameter logic [7:0] TIMEOUT_RESP = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [15:0]            cmd_data,
  output logic                   cmd_err,
  output logic [N_SENSORS-1:0]   sensor_en,
  output logic [7:0]             sensor_req,
  input  logic [N_SENSORS-1:0]   sensor_done,
  input  logic [8*N_SENSORS-1:0] sensor_data,
  input  logic [6*N_SENSORS-1:0] sensor_resp,
  output logic                   dec_en,
  output logic [7:0]             dec_data,
  output logic [7:0]             dec_resp,
  output logic [7:0]             dec_addr,
  input  logic                   dec_done,
  output logic [N_SENSORS-1:0]   temp_cont_o,
  output logic [N_SENSORS-1:0]   umid_cont_o,
  output logic [2:0]             state_o
);

  // Continuous slots: 0..N-1 temperature, N..2N-1 humidity.
  localparam int NS = 2 * N_SENSORS;
  localparam int SW = $clog2(NS);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_ISSUE        = 3'd1;
  localparam logic [2:0] S_WAIT_SENSOR  = 3'd2;
  localparam logic [2:0] S_DECODE       = 3'd3;
  localparam logic [2:0] S_WAIT_DECODER = 3'd4;

  logic [2:0]           r_state;
  logic                 r_cmd_err;
  logic [N_SENSORS-1:0] r_temp_mask;
  logic [N_SENSORS-1:0] r_umid_mask;
  logic                 r_buf_valid;
  logic [7:0]           r_buf_req;
  logic [7:0]           r_buf_addr;
  logic [N_SENSORS-1:0] r_buf_oh;
  logic [7:0]           r_req;
  logic [7:0]           r_addr;
  logic [N_SENSORS-1:0] r_ch_oh;
  logic                 r_cont;
  logic [SW-1:0]        r_slot;
  logic [SW-1:0]        r_rr_ptr;
  logic [31:0]          r_cnt;
  logic [7:0]           r_dec_data;
  logic [7:0]           r_dec_resp;
  logic [7:0]           r_dec_addr;

  logic [7:0]           w_op;
  logic [7:0]           w_addr;
  logic [N_SENSORS-1:0] w_addr_oh;
  logic                 w_addr_ok;
  logic                 w_op_ok;
  logic                 w_is_mask;
  logic                 w_buf_busy;
  logic [NS-1:0]        w_slots;
  logic                 w_found;
  logic [SW-1:0]        w_pick_slot;
  logic                 w_pick_umid;
  logic [SW-1:0]        w_pick_sensor;
  logic [N_SENSORS-1:0] w_pick_oh;
  logic [7:0]           w_pick_addr;
  logic                 w_sel_done;
  logic [7:0]           w_sel_data;
  logic [5:0]           w_sel_resp;
  logic                 w_timeout;

  assign w_op      = cmd_data[15:8];
  assign w_addr    = cmd_data[7:0];
  assign w_op_ok   = (w_op >= 8'h31) && (w_op <= 8'h37);
  assign w_is_mask = (w_op >= 8'h34);
  assign w_addr_ok = |w_addr_oh;
  // The buffer entry being issued this cycle is already considered free.
  assign w_buf_busy = r_buf_valid && !((r_state == S_ISSUE) && !r_cont);
  assign w_slots   = {r_umid_mask, r_temp_mask};
  assign w_timeout = (r_cnt == 32'(TIMEOUT_CYC - 1));

  assign w_pick_umid   = (w_pick_slot >= SW'(N_SENSORS));
  assign w_pick_sensor = w_pick_umid ? (w_pick_slot - SW'(N_SENSORS)) : w_pick_slot;
  assign w_pick_addr   = 8'h31 + 8'(w_pick_sensor);

  // Address decode and slot-to-channel decode as one-hot vectors.
  for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_chan
    assign w_addr_oh[gi] = (w_addr == 8'(8'h31 + gi));
    assign w_pick_oh[gi] = (w_pick_sensor == SW'(gi));
  end

  // Round-robin search: first enabled slot at or after r_rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    w_found     = 1'b0;
    w_pick_slot = '0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NS) idx = idx - NS;
      if (!w_found && w_slots[SW'(idx)]) begin
        w_found     = 1'b1;
        w_pick_slot = SW'(idx);
      end
    end
  end

  // Result mux for the channel currently being served.
  always_comb begin
    w_sel_done = |(sensor_done & r_ch_oh);
    w_sel_data = '0;
    w_sel_resp = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      w_sel_data = w_sel_data | (sensor_data[8*i +: 8] & {8{r_ch_oh[i]}});
      w_sel_resp = w_sel_resp | (sensor_resp[6*i +: 6] & {6{r_ch_oh[i]}});
    end
  end

  // Command intake: mask updates, one-shot buffer, and drop reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_err   <= 1'b0;
      r_temp_mask <= '0;
      r_umid_mask <= '0;
      r_buf_valid <= 1'b0;
      r_buf_req   <= '0;
      r_buf_addr  <= '0;
      r_buf_oh    <= '0;
    end else begin
      r_cmd_err <= 1'b0;
      if ((r_state == S_ISSUE) && !r_cont) r_buf_valid <= 1'b0;
      if (cmd_valid) begin
        if (!w_op_ok || !w_addr_ok) begin
          r_cmd_err <= 1'b1;
        end else if (w_is_mask) begin
          case (w_op)
            8'h34:   r_temp_mask <= r_temp_mask | w_addr_oh;
            8'h35:   r_umid_mask <= r_umid_mask | w_addr_oh;
            8'h36:   r_temp_mask <= r_temp_mask & ~w_addr_oh;
            default: r_umid_mask <= r_umid_mask & ~w_addr_oh;
          endcase
        end else if (w_buf_busy) begin
          r_cmd_err <= 1'b1;
        end else begin
          r_buf_valid <= 1'b1;
          r_buf_req   <= w_op;
          r_buf_addr  <= w_addr;
          r_buf_oh    <= w_addr_oh;
        end
      end
    end
  end

  // Access sequencer: pick a job, start the sensor, wait or time out, hand off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_addr     <= '0;
      r_ch_oh    <= '0;
      r_cont     <= 1'b0;
      r_slot     <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_dec_data <= '0;
      r_dec_resp <= '0;
      r_dec_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_buf_valid) begin
            r_req   <= r_buf_req;
            r_addr  <= r_buf_addr;
            r_ch_oh <= r_buf_oh;
            r_cont  <= 1'b0;
            r_state <= S_ISSUE;
          end else if (w_found) begin
            r_req   <= w_pick_umid ? 8'h33 : 8'h32;
            r_addr  <= w_pick_addr;
            r_ch_oh <= w_pick_oh;
            r_cont  <= 1'b1;
            r_slot  <= w_pick_slot;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_SENSOR;
        end
        S_WAIT_SENSOR: begin
          if (w_sel_done) begin
            r_dec_data <= w_sel_data;
            r_dec_resp <= {2'b00, w_sel_resp};
            r_dec_addr <= r_addr;
            r_state    <= S_DECODE;
          end else if (w_timeout) begin
            r_dec_data <= 8'h00;
            r_dec_resp <= TIMEOUT_RESP;
            r_dec_addr <= r_addr;
            r_state    <= S_DECODE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_DECODE: r_state <= S_WAIT_DECODER;
        S_WAIT_DECODER: begin
          if (dec_done) begin
            r_state <= S_IDLE;
            if (r_cont) r_rr_ptr <= (r_slot == SW'(NS - 1)) ? '0 : r_slot + SW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_err     = r_cmd_err;
  assign sensor_en   = (r_state == S_ISSUE) ? r_ch_oh : '0;
  assign sensor_req  = r_req;
  assign dec_en      = (r_state == S_DECODE);
  assign dec_data    = r_dec_data;
  assign dec_resp    = r_dec_resp;
  assign dec_addr    = r_dec_addr;
  assign temp_cont_o = r_temp_mask;
  assign umid_cont_o = r_umid_mask;
  assign state_o     = r_state;

endmodule

// File: tb/tb_sensor_scheduler_rr.sv
// Self-checking bench for sensor_scheduler_rr with a short timeout.
module tb_sensor_scheduler_rr;
  localparam int N  = 8;
  localparam int TO = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [15:0]    cmd_data = '0;
  logic           cmd_err;
  logic [N-1:0]   sensor_en;
  logic [7:0]     sensor_req;
  logic [N-1:0]   sensor_done = '0;
  logic [8*N-1:0] sensor_data = '0;
  logic [6*N-1:0] sensor_resp = '0;
  logic           dec_en;
  logic [7:0]     dec_data;
  logic [7:0]     dec_resp;
  logic [7:0]     dec_addr;
  logic           dec_done = 1'b0;
  logic [N-1:0]   temp_cont_o;
  logic [N-1:0]   umid_cont_o;
  logic [2:0]     state_o;

  int checks = 0;
  int failures = 0;

  sensor_scheduler_rr #(.N_SENSORS(N), .TIMEOUT_CYC(TO), .TIMEOUT_RESP(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_err(cmd_err),
    .sensor_en(sensor_en), .sensor_req(sensor_req), .sensor_done(sensor_done),
    .sensor_data(sensor_data), .sensor_resp(sensor_resp), .dec_en(dec_en),
    .dec_data(dec_data), .dec_resp(dec_resp), .dec_addr(dec_addr), .dec_done(dec_done),
    .temp_cont_o(temp_cont_o), .umid_cont_o(umid_cont_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference round-robin rule: list enabled slots, take first at/after ptr, else wrap.
  function automatic int rr_expect(input int ptr, input logic [N-1:0] tm, input logic [N-1:0] um);
    int q[$];
    logic [2*N-1:0] en;
    en = {um, tm};
    for (int s = 0; s < 2*N; s++) if (en[s[3:0]]) q.push_back(s);
    if (q.size() == 0) return -1;
    foreach (q[i]) if (q[i] >= ptr) return q[i];
    return q[0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; sensor_done = '0;
    sensor_data = '0; sensor_resp = '0; dec_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] d, output logic err);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = d;
    @(negedge clk);
    err = cmd_err; cmd_valid = 1'b0;
  endtask

  // Plays one sensor interface access and the decoder handshake, reporting what was seen.
  task automatic serve(input bit skip_wait, input int delay, input bit give_done,
                       input logic [7:0] d_in, input logic [5:0] r_in,
                       output int ch, output logic [7:0] req, output logic [7:0] o_data,
                       output logic [7:0] o_resp, output logic [7:0] o_addr, output int lat,
                       output int extra, output bit ok, output logic [2:0] st_after);
    int guard;
    logic [N-1:0] en;
    ok = 1'b1; ch = -1; req = '0; o_data = '0; o_resp = '0; o_addr = '0;
    lat = 0; extra = 0; st_after = 3'd7;
    if (!skip_wait) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (sensor_en == '0 && guard < 60);
      if (sensor_en == '0) begin ok = 1'b0; return; end
    end
    en = sensor_en; req = sensor_req;
    for (int i = 0; i < N; i++) if (en == (N'(1) << i)) ch = i;
    if (ch < 0) begin ok = 1'b0; return; end
    if (give_done) begin
      for (int i = 0; i <= delay; i++) begin
        @(negedge clk); lat++;
        if (sensor_en != '0) extra++;
        sensor_done = N'($urandom) & ~en;
        dec_done = 1'($urandom_range(0, 1));
      end
      sensor_done = en; sensor_data[8*ch +: 8] = d_in; sensor_resp[6*ch +: 6] = r_in;
      dec_done = 1'b0;
    end
    guard = 0;
    do begin
      @(negedge clk); lat++; guard++;
      sensor_done = give_done ? '0 : (N'($urandom) & ~en);
      if (sensor_en != '0) extra++;
    end while (!dec_en && guard < 4*TO);
    sensor_done = '0;
    if (!dec_en) begin ok = 1'b0; return; end
    o_data = dec_data; o_resp = dec_resp; o_addr = dec_addr;
    @(negedge clk); if (dec_en || sensor_en != '0) extra++;
    @(negedge clk); if (dec_en) extra++;
    if (dec_data !== o_data || dec_resp !== o_resp || dec_addr !== o_addr) extra++;
    dec_done = 1'b1;
    @(negedge clk); dec_done = 1'b0; st_after = state_o;
    $display("txn ch=%0d req=%0h addr=%0h data=%0h resp=%0h lat=%0d", ch, req, o_addr, o_data, o_resp, lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({cmd_err, sensor_en, sensor_req, dec_en, dec_data, dec_resp, dec_addr, temp_cont_o, umid_cont_o, state_o} !== '0) begin failures++; $display("FAIL reset_outputs got nonzero en=%0h req=%0h st=%0d", sensor_en, sensor_req, state_o); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_idle got=%0d exp=0", state_o); end
    checks++; if (sensor_en !== '0) begin failures++; $display("FAIL reset_no_en got=%0h exp=0", sensor_en); end
  endtask

  task automatic test_one_shot();
    logic err; int ch, lat, extra; bit ok; logic [7:0] req, od, ors, oa; logic [2:0] st; logic [5:0] r;
    do_reset();
    r = 6'($urandom);
    send_cmd(16'h3132, err);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL oneshot_err got=%0b exp=0", err); end
    @(negedge clk);
    checks++; if (sensor_en !== 8'h02) begin failures++; $display("FAIL oneshot_latency_en got=%0h exp=02", sensor_en); end
    checks++; if (sensor_req !== 8'h31) begin failures++; $display("FAIL oneshot_req got=%0h exp=31", sensor_req); end
    serve(1'b1, 10, 1'b1, 8'h1A, r, ch, req, od, ors, oa, lat, extra, ok, st);
    checks++; if (!ok || ch !== 1) begin failures++; $display("FAIL oneshot_ch got=%0d ok=%0b exp=1", ch, ok); end
    checks++; if (oa !== 8'h32) begin failures++; $display("FAIL oneshot_addr got=%0h exp=32", oa); end
    checks++; if (od !== 8'h1A) begin failures++; $display("FAIL oneshot_data got=%0h exp=1a", od); end
    checks++; if (ors !== {2'b00, r}) begin failures++; $display("FAIL oneshot_resp got=%0h exp=%0h", ors, {2'b00, r}); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL oneshot_pulses got=%0d exp=0", extra); end
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL oneshot_idle got=%0d exp=0", st); end
  endtask

  task automatic test_round_robin();
    logic e0, e1, e2, e3; int ch, lat, extra, ptr, e; bit ok; logic [7:0] req, od, ors, oa; logic [2:0] st;
    int obs_slot[6]; logic [7:0] obs_addr[6], obs_data[6], exp_data[6];
    logic [N-1:0] tm, um;
    do_reset();
    for (int k = 0; k < 6; k++) exp_data[k] = 8'($urandom);
    fork
      begin
        send_cmd(16'h3431, e0); send_cmd(16'h3533, e1); send_cmd(16'h3438, e2);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          serve(1'b0, $urandom_range(0, 6), 1'b1, exp_data[k], 6'($urandom), ch, req, od, ors, oa, lat, extra, ok, st);
          obs_slot[k] = !ok ? -1 : (req == 8'h32) ? ch : (req == 8'h33) ? N + ch : -2;
          obs_addr[k] = oa; obs_data[k] = od;
        end
      end
    join
    checks++; if ({e0, e1, e2} !== 3'b000) begin failures++; $display("FAIL rr_mask_err got=%0b exp=000", {e0, e1, e2}); end
    tm = 8'h81; um = 8'h04;
    checks++; if ({temp_cont_o, umid_cont_o} !== {tm, um}) begin failures++; $display("FAIL rr_masks got=%0h/%0h exp=%0h/%0h", temp_cont_o, umid_cont_o, tm, um); end
    ptr = 0;
    for (int k = 0; k < 6; k++) begin
      e = rr_expect(ptr, tm, um);
      checks++; if (obs_slot[k] !== e) begin failures++; $display("FAIL rr_slot[%0d] got=%0d exp=%0d", k, obs_slot[k], e); end
      checks++; if (obs_addr[k] !== 8'(8'h31 + e % N)) begin failures++; $display("FAIL rr_addr[%0d] got=%0h exp=%0h", k, obs_addr[k], 8'(8'h31 + e % N)); end
      checks++; if (obs_data[k] !== exp_data[k]) begin failures++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", k, obs_data[k], exp_data[k]); end
      ptr = (e + 1) % (2*N);
    end
    // Clearing the mask of the slot in service lets that access finish normally.
    e = rr_expect(ptr, tm, um);
    fork
      serve(1'b0, 8, 1'b1, 8'h5C, 6'h11, ch, req, od, ors, oa, lat, extra, ok, st);
      begin repeat (4) @(negedge clk); send_cmd(16'h3631, e3); end
    join
    tm = tm & ~8'h01;
    checks++; if (!ok || ((req == 8'h33) ? N + ch : ch) !== e || od !== 8'h5C) begin failures++; $display("FAIL rr_clear_inflight got slot ch=%0d req=%0h data=%0h exp slot=%0d data=5c", ch, req, od, e); end
    checks++; if (temp_cont_o !== tm || e3 !== 1'b0) begin failures++; $display("FAIL rr_clear_mask got=%0h err=%0b exp=%0h", temp_cont_o, e3, tm); end
    ptr = (e + 1) % (2*N);
    e = rr_expect(ptr, tm, um);
    serve(1'b0, 3, 1'b1, 8'h77, 6'h02, ch, req, od, ors, oa, lat, extra, ok, st);
    checks++; if (!ok || ((req == 8'h33) ? N + ch : ch) !== e) begin failures++; $display("FAIL rr_after_clear got ch=%0d req=%0h exp slot=%0d", ch, req, e); end
  endtask

  task automatic test_timeout();
    logic err; int ch, lat, extra; bit ok; logic [7:0] req, od, ors, oa; logic [2:0] st;
    do_reset();
    send_cmd(16'h3233, err);
    serve(1'b0, 0, 1'b0, 8'h00, 6'h00, ch, req, od, ors, oa, lat, extra, ok, st);
    checks++; if (!ok || ch !== 2 || req !== 8'h32) begin failures++; $display("FAIL timeout_issue got ch=%0d req=%0h ok=%0b exp ch=2 req=32", ch, req, ok); end
    checks++; if (lat !== TO + 1) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", lat, TO + 1); end
    checks++; if (ors !== 8'hFF) begin failures++; $display("FAIL timeout_resp got=%0h exp=ff", ors); end
    checks++; if (od !== 8'h00 || oa !== 8'h33) begin failures++; $display("FAIL timeout_data got=%0h/%0h exp=00/33", od, oa); end
    checks++; if (st !== 3'd0 || extra !== 0) begin failures++; $display("FAIL timeout_idle got st=%0d extra=%0d exp 0/0", st, extra); end
  endtask

  task automatic test_priority();
    logic e0, e1, e2; int ch, lat, extra; bit ok; logic [7:0] req, od, ors, oa; logic [2:0] st;
    do_reset();
    fork
      begin
        send_cmd(16'h3431, e0); repeat (3) @(negedge clk);
        send_cmd(16'h3132, e1); send_cmd(16'h3332, e2);
      end
      serve(1'b0, 14, 1'b1, 8'h10, 6'h01, ch, req, od, ors, oa, lat, extra, ok, st);
    join
    checks++; if (!ok || ch !== 0 || req !== 8'h32) begin failures++; $display("FAIL prio_first got ch=%0d req=%0h exp ch=0 req=32", ch, req); end
    checks++; if ({e0, e1, e2} !== 3'b001) begin failures++; $display("FAIL prio_overrun_err got=%0b exp=001", {e0, e1, e2}); end
    serve(1'b0, 2, 1'b1, 8'h21, 6'h05, ch, req, od, ors, oa, lat, extra, ok, st);
    checks++; if (!ok || ch !== 1 || req !== 8'h31 || oa !== 8'h32 || od !== 8'h21) begin failures++; $display("FAIL prio_oneshot got ch=%0d req=%0h addr=%0h data=%0h exp 1/31/32/21", ch, req, oa, od); end
    serve(1'b0, 2, 1'b1, 8'h22, 6'h06, ch, req, od, ors, oa, lat, extra, ok, st);
    checks++; if (!ok || ch !== 0 || req !== 8'h32) begin failures++; $display("FAIL prio_resume got ch=%0d req=%0h exp ch=0 req=32", ch, req); end
  endtask

  task automatic test_illegal();
    logic err; int bad;
    logic [15:0] cmds[4] = '{16'h3839, 16'h3139, 16'h3130, 16'h3038};
    do_reset();
    foreach (cmds[i]) begin
      send_cmd(cmds[i], err);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err[%0h] got=%0b exp=1", cmds[i], err); end
    end
    bad = 0;
    repeat (6) begin @(negedge clk); if (sensor_en != '0 || state_o != 3'd0 || cmd_err) bad++; end
    checks++; if (bad !== 0) begin failures++; $display("FAIL illegal_quiet got=%0d exp=0", bad); end
    checks++; if ({temp_cont_o, umid_cont_o} !== '0) begin failures++; $display("FAIL illegal_masks got=%0h/%0h exp=0/0", temp_cont_o, umid_cont_o); end
    send_cmd(16'h3738, err);
    checks++; if (err !== 1'b0 || umid_cont_o !== '0) begin failures++; $display("FAIL edge_addr_off got err=%0b mask=%0h exp 0/0", err, umid_cont_o); end
    send_cmd(16'h3438, err);
    checks++; if (err !== 1'b0 || temp_cont_o !== 8'h80) begin failures++; $display("FAIL edge_addr_on got err=%0b mask=%0h exp 0/80", err, temp_cont_o); end
  endtask

  task automatic test_random_oneshot();
    logic err; int ch, lat, extra, c; bit ok; logic [7:0] req, od, ors, oa, op, d; logic [2:0] st; logic [5:0] r;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      c = $urandom_range(0, N - 1); op = 8'($urandom_range(8'h31, 8'h33));
      d = 8'($urandom); r = 6'($urandom);
      send_cmd({op, 8'(8'h31 + c)}, err);
      serve(1'b0, $urandom_range(0, 15), 1'b1, d, r, ch, req, od, ors, oa, lat, extra, ok, st);
      checks++; if (!ok || err !== 1'b0 || ch !== c || req !== op) begin failures++; $display("FAIL rand_issue[%0d] got ch=%0d req=%0h err=%0b exp ch=%0d req=%0h", k, ch, req, err, c, op); end
      checks++; if (oa !== 8'(8'h31 + c) || od !== d || ors !== {2'b00, r}) begin failures++; $display("FAIL rand_result[%0d] got %0h/%0h/%0h exp %0h/%0h/%0h", k, oa, od, ors, 8'(8'h31 + c), d, {2'b00, r}); end
      checks++; if (extra !== 0 || st !== 3'd0) begin failures++; $display("FAIL rand_handshake[%0d] got extra=%0d st=%0d exp 0/0", k, extra, st); end
    end
  endtask

  task automatic test_reset_mid();
    logic err; int bad;
    do_reset();
    send_cmd(16'h3431, err); send_cmd(16'h3535, err);
    repeat (4) @(negedge clk);
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL midreset_pre_state got=%0d exp=2", state_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_err, sensor_en, sensor_req, dec_en, dec_data, dec_resp, dec_addr, temp_cont_o, umid_cont_o, state_o} !== '0) begin failures++; $display("FAIL midreset_outputs got masks=%0h/%0h st=%0d req=%0h", temp_cont_o, umid_cont_o, state_o, sensor_req); end
    @(negedge clk);
    rst_n = 1'b1;
    sensor_done = '1; sensor_data = {N{8'h5A}};
    bad = 0;
    repeat (20) begin @(negedge clk); sensor_done = '0; if (dec_en || sensor_en != '0 || state_o != 3'd0) bad++; end
    checks++; if (bad !== 0) begin failures++; $display("FAIL midreset_no_dec got=%0d exp=0", bad); end
    checks++; if ({temp_cont_o, umid_cont_o} !== '0) begin failures++; $display("FAIL midreset_masks got=%0h/%0h exp=0/0", temp_cont_o, umid_cont_o); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_round_robin();
    test_timeout();
    test_priority();
    test_illegal();
    test_random_oneshot();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
